// File: rtl/instr_mem_responder.sv
// Instruction memory responder: fixed-latency word reads for the fetch stage plus a loader write port.
// Optional feature macro IMEM_PARITY_EN adds a per-word even-parity bit with load-time error injection.
module instr_mem_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] FAULT_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  output logic        fetch_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic        load_parity_inv,
`endif
  output logic        load_err,
  output logic [2:0]  inflight
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT = READ_LATENCY;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_responder: READ_LATENCY=%0d outside 1..4", READ_LATENCY);
  end
  if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 || (1 << AW) != DEPTH_WORDS) begin : g_bad_depth
    $error("instr_mem_responder: DEPTH_WORDS=%0d must be a power of two in 16..65536", DEPTH_WORDS);
  end

  // Misaligned or beyond the last word.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (32'(a[31:2]) >= 32'(DEPTH_WORDS));
  endfunction

  logic [AW-1:0] f_idx;
  logic [AW-1:0] l_idx;
  logic          f_bad;
  logic          l_bad;
  logic          load_ok;

  assign f_idx   = fetch_addr[AW+1:2];
  assign l_idx   = load_addr[AW+1:2];
  assign f_bad   = addr_bad(fetch_addr);
  assign l_bad   = addr_bad(load_addr);
  assign load_ok = load_we & ~l_bad;

  // Storage is deliberately not reset so a loaded program survives reset.
  logic [31:0] mem_q [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
  logic        par_q [DEPTH_WORDS];
`endif

  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem_q[l_idx] <= load_data;
`ifdef IMEM_PARITY_EN
      par_q[l_idx] <= (^load_data) ^ load_parity_inv;
`endif
    end
  end

  // Asynchronous read sampled into stage 0, so a same-edge load is seen only by later fetches.
  logic [31:0] rd_word;
  logic        rd_fault;

  always_comb begin
    rd_word  = mem_q[f_idx];
    rd_fault = f_bad;
`ifdef IMEM_PARITY_EN
    rd_fault = f_bad | ((^rd_word) ^ par_q[f_idx]);
`endif
  end

  for (genvar g = 0; g < LAT; g++) begin : g_stage
    logic        vld_in;
    logic        flt_in;
    logic [31:0] dat_in;
    logic        vld_q;
    logic        flt_q;
    logic [31:0] dat_q;
    logic [31:0] dat_d;

    if (g == 0) begin : g_head
      assign vld_in = fetch_req;
      assign flt_in = fetch_req & rd_fault;
      assign dat_in = rd_fault ? FAULT_WORD : rd_word;
    end else begin : g_body
      assign vld_in = g_stage[g-1].vld_q;
      assign flt_in = g_stage[g-1].flt_q;
      assign dat_in = g_stage[g-1].dat_q;
    end

    // Data only moves with a valid entry so the output word holds between responses.
    always_comb begin
      dat_d = dat_q;
      if (vld_in) begin
        dat_d = dat_in;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        flt_q <= 1'b0;
        dat_q <= 32'h0;
      end else begin
        vld_q <= vld_in;
        flt_q <= flt_in;
        dat_q <= dat_d;
      end
    end
  end

  assign fetch_valid = g_stage[LAT-1].vld_q;
  assign fetch_fault = g_stage[LAT-1].flt_q;
  assign fetch_data  = g_stage[LAT-1].dat_q;

  // The response leaving the last stage retires at the same edge a new request may enter.
  logic [2:0] inflight_q;
  logic [2:0] inflight_d;
  logic       load_err_q;
  logic       load_err_d;

  always_comb begin
    inflight_d = inflight_q + 3'(fetch_req) - 3'(fetch_valid);
    load_err_d = load_we & l_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_q <= 3'd0;
      load_err_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      load_err_q <= load_err_d;
    end
  end

  assign inflight = inflight_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: one responder at latency 1 and one at latency 3 share the same stimulus.
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;
`ifdef IMEM_PARITY_EN
  logic        load_parity_inv;
`endif

  logic        v1, f1, e1;
  logic [31:0] d1;
  logic [2:0]  i1;
  logic        v3, f3, e3;
  logic [31:0] d3;
  logic [2:0]  i3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .FAULT_WORD(32'h0000_0000)) u_lat1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(v1), .fetch_data(d1), .fetch_fault(f1),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_parity_inv(load_parity_inv),
`endif
    .load_err(e1), .inflight(i1)
  );

  instr_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .FAULT_WORD(32'h0000_0000)) u_lat3 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(v3), .fetch_data(d3), .fetch_fault(f3),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`ifdef IMEM_PARITY_EN
    .load_parity_inv(load_parity_inv),
`endif
    .load_err(e3), .inflight(i3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    load_we    = 1'b0;
    load_addr  = 32'h0;
    load_data  = 32'h0;
`ifdef IMEM_PARITY_EN
    load_parity_inv = 1'b0;
`endif
    tick();
    tick();
    chk("rst_valid1", v1, 0);
    chk("rst_data1", d1, 32'h0);
    chk("rst_fault1", f1, 0);
    chk("rst_lerr1", e1, 0);
    chk("rst_infl1", i1, 0);
    chk("rst_valid3", v3, 0);
    chk("rst_infl3", i3, 0);
    reset = 1'b0;
    tick();

    // T1: program load then back-to-back fetches
    load_we = 1'b1; load_addr = 32'h0; load_data = 32'h1234_5678;
    tick();
    load_addr = 32'h4; load_data = 32'hC000_0004;
    tick();
    load_addr = 32'h8; load_data = 32'h5555_5555;
    tick();
    load_we = 1'b0;
    chk("t1_lerr", e1, 0);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    chk("t1_v1_a", v1, 1);
    chk("t1_d1_a", d1, 32'h1234_5678);
    chk("t1_f1_a", f1, 0);
    chk("t1_i1_a", i1, 1);
    chk("t1_v3_a", v3, 0);
    chk("t1_i3_a", i3, 1);
    fetch_addr = 32'h4;
    tick();
    chk("t1_v1_b", v1, 1);
    chk("t1_d1_b", d1, 32'hC000_0004);
    chk("t1_i1_b", i1, 1);
    chk("t1_i3_b", i3, 2);
    fetch_req = 1'b0;
    tick();
    chk("t1_v1_c", v1, 0);
    chk("t1_d1_hold", d1, 32'hC000_0004);
    chk("t1_i1_c", i1, 0);
    chk("t1_v3_c", v3, 1);
    chk("t1_d3_c", d3, 32'h1234_5678);
    chk("t1_i3_c", i3, 2);
    tick();
    chk("t1_v3_d", v3, 1);
    chk("t1_d3_d", d3, 32'hC000_0004);
    chk("t1_i3_d", i3, 1);
    tick();
    chk("t1_v3_e", v3, 0);
    chk("t1_i3_e", i3, 0);

    // T2: faulted fetches and rejected load
    fetch_req = 1'b1; fetch_addr = 32'h2;
    tick();
    chk("t2_mis_v", v1, 1);
    chk("t2_mis_f", f1, 1);
    chk("t2_mis_d", d1, 32'h0);
    fetch_addr = 32'h1000;
    tick();
    chk("t2_oor_v", v1, 1);
    chk("t2_oor_f", f1, 1);
    chk("t2_oor_d", d1, 32'h0);
    fetch_req = 1'b0;
    load_we = 1'b1; load_addr = 32'h6; load_data = 32'hFFFF_FFFF;
    tick();
    chk("t2_lerr1", e1, 1);
    chk("t2_lerr3", e3, 1);
    chk("t2_idle_f", f1, 0);
    load_we = 1'b0;
    tick();
    chk("t2_lerr_end", e1, 0);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    tick();
    chk("t2_w1_d", d1, 32'hC000_0004);
    chk("t2_w1_f", f1, 0);
    fetch_req = 1'b0;
    tick();
    tick();
    tick();

    // T3: same-cycle load and fetch of one word
    load_we = 1'b1; load_addr = 32'h8; load_data = 32'hAAAA_AAAA;
    fetch_req = 1'b1; fetch_addr = 32'h8;
    tick();
    chk("t3_old", d1, 32'h5555_5555);
    load_we = 1'b0;
    tick();
    chk("t3_new", d1, 32'hAAAA_AAAA);
    fetch_req = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_i3_idle", i3, 0);

    // T4: three back-to-back fetches at latency 3
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    chk("t4_i3_1", i3, 1);
    chk("t4_v3_1", v3, 0);
    fetch_addr = 32'h4;
    tick();
    chk("t4_i3_2", i3, 2);
    chk("t4_v3_2", v3, 0);
    fetch_addr = 32'h8;
    tick();
    chk("t4_i3_3", i3, 3);
    chk("t4_v3_3", v3, 1);
    chk("t4_d3_3", d3, 32'h1234_5678);
    fetch_req = 1'b0;
    tick();
    chk("t4_i3_4", i3, 2);
    chk("t4_v3_4", v3, 1);
    chk("t4_d3_4", d3, 32'hC000_0004);
    tick();
    chk("t4_i3_5", i3, 1);
    chk("t4_v3_5", v3, 1);
    chk("t4_d3_5", d3, 32'hAAAA_AAAA);
    tick();
    chk("t4_i3_6", i3, 0);
    chk("t4_v3_6", v3, 0);

    // T5: reset with requests in flight
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4;
    tick();
    chk("t5_i3_pre", i3, 2);
    fetch_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_i3_rst", i3, 0);
    chk("t5_v3_rst", v3, 0);
    chk("t5_d3_rst", d3, 32'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_quiet3", v3, 0);
      chk("t5_quiet1", v1, 0);
    end
    fetch_req = 1'b1; fetch_addr = 32'h4;
    tick();
    chk("t5_d1_keep", d1, 32'hC000_0004);
    chk("t5_v1", v1, 1);
    fetch_req = 1'b0;
    tick();
    chk("t5_v3_early", v3, 0);
    tick();
    chk("t5_v3", v3, 1);
    chk("t5_d3_keep", d3, 32'hC000_0004);
    tick();

`ifdef IMEM_PARITY_EN
    // T6: parity error injection
    load_we = 1'b1; load_addr = 32'h10; load_data = 32'h0000_0001; load_parity_inv = 1'b1;
    tick();
    load_we = 1'b0; load_parity_inv = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h10;
    tick();
    chk("t6_bad_f", f1, 1);
    chk("t6_bad_d", d1, 32'h0);
    fetch_req = 1'b0;
    load_we = 1'b1;
    tick();
    load_we = 1'b0;
    fetch_req = 1'b1;
    tick();
    chk("t6_good_f", f1, 0);
    chk("t6_good_d", d1, 32'h0000_0001);
    fetch_req = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
